ysyx_24100006_axi_arbiter: RTL and testbench
============================================

Name:
ysyx_24100006_axi_arbiter

Overview:
Two-master to one-master AXI-lite arbiter between the core masters (IFU read-only, LSU read/write) and the address-decoding crossbar. Grants one master at a time, holds the grant for exactly one transaction until its response handshake completes, and alternates grants round-robin under contention.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, data width; write strobe fixed at 8 bits to match the crossbar

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ifu_axi_arvalid in 1 / ifu_axi_arready out 1 / ifu_axi_araddr in 32  IFU read address
ifu_axi_rvalid out 1 / ifu_axi_rready in 1 / ifu_axi_rdata out 32 / ifu_axi_rresp out 2  IFU read data
lsu_axi_awvalid in 1 / lsu_axi_awready out 1 / lsu_axi_awaddr in 32  LSU write address
lsu_axi_wvalid in 1 / lsu_axi_wready out 1 / lsu_axi_wdata in 32 / lsu_axi_wstrb in 8  LSU write data
lsu_axi_bvalid out 1 / lsu_axi_bready in 1 / lsu_axi_bresp out 2  LSU write response
lsu_axi_arvalid in 1 / lsu_axi_arready out 1 / lsu_axi_araddr in 32  LSU read address
lsu_axi_rvalid out 1 / lsu_axi_rready in 1 / lsu_axi_rdata out 32 / lsu_axi_rresp out 2  LSU read data
m_axi_awvalid out 1 / m_axi_awready in 1 / m_axi_awaddr out 32  write address to crossbar
m_axi_wvalid out 1 / m_axi_wready in 1 / m_axi_wdata out 32 / m_axi_wstrb out 8  write data to crossbar
m_axi_bvalid in 1 / m_axi_bready out 1 / m_axi_bresp in 2  write response from crossbar
m_axi_arvalid out 1 / m_axi_arready in 1 / m_axi_araddr out 32  read address to crossbar
m_axi_rvalid in 1 / m_axi_rready out 1 / m_axi_rdata in 32 / m_axi_rresp in 2  read data from crossbar

Behaviour:
- State register: IDLE, IFU_RD, LSU_RD, LSU_WR; plus last_grant (0=IFU, 1=LSU). Reset (async, any time, including mid-transaction): state=IDLE, last_grant=LSU, so IFU wins the first tie.
- All outputs are combinational from state. In IDLE every valid/ready output is 0 and every data/addr/strb/resp output is 0; the same holds during reset.
- Requests: ifu_req=ifu_axi_arvalid; lsu_rd=lsu_axi_arvalid; lsu_wr=lsu_axi_awvalid|lsu_axi_wvalid; lsu_req=lsu_rd|lsu_wr.
- IDLE transitions (registered, 1-cycle arbitration latency): ifu_req only -> IFU_RD; lsu_req only -> LSU_RD if lsu_rd else LSU_WR; both -> the master not equal to last_grant. LSU asserting read and write together -> LSU_RD first. Entering a grant state updates last_grant.
- IFU_RD: m_ar*/m_r* connect to ifu_axi_ar*/ifu_axi_r*. LSU gets all ready/valid = 0. Exit to IDLE on the cycle m_axi_rvalid & ifu_axi_rready.
- LSU_RD: m_ar*/m_r* connect to lsu_axi_ar*/lsu_axi_r*. Exit on m_axi_rvalid & lsu_axi_rready.
- LSU_WR: m_aw*/m_w*/m_b* connect to LSU. AW and W are forwarded independently, in either order or the same cycle. Exit on m_axi_bvalid & lsu_axi_bready.
- In read states m_aw/m_w/m_bready = 0. In LSU_WR m_arvalid/m_rready = 0.
- The arbiter never drops a valid once forwarded; masters hold payload stable per AXI.
- After exit, a new grant needs at least one IDLE cycle, so back-to-back transactions are spaced by 1 cycle.
- rresp/bresp pass through unmodified; an error response still ends the transaction.
- The arbiter adds no buffering: response data is never stored.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, IFU_RD=2'd1, LSU_RD=2'd2, LSU_WR=2'd3) and grant constants GNT_IFU=0, GNT_LSU=1.
- Single module; no sub-module warranted.

Test Plan:
- Reset, then IFU arvalid with araddr=0x8000_0000 and slave rdata=0x0000_0413 -> m_axi_arvalid rises 1 cycle after the request; ifu_axi_rdata=0x413; state returns to IDLE after the r handshake; lsu_axi_arready=0 throughout.
- IFU and LSU read both asserted in the same cycle, 3 times back-to-back -> grants go IFU, LSU, IFU; each losing master sees arready=0 until its turn.
- LSU write awaddr=0xa000_03f8, wdata=0x41, wstrb=0x01; slave accepts W 2 cycles before AW -> both forwarded; lsu_axi_bvalid follows m_axi_bvalid; IFU is blocked until the b handshake.
- LSU asserts arvalid and awvalid together -> read completes first, then one IDLE cycle, then the write proceeds.
- Reset asserted while LSU_RD has m_axi_rvalid pending -> outputs go to 0 immediately (asynchronously); after release the state is IDLE and IFU wins the next tie.
- Slave returns rresp=2'b10 on an IFU read -> ifu_axi_rresp=2'b10 and the arbiter returns to IDLE normally.

Source files
------------

// File: rtl/ysyx_24100006_axi_arbiter_pkg.sv
// Shared encodings for the IFU/LSU AXI-lite arbiter: FSM states, grant
// identifiers and the round-robin tie-break helper.
package ysyx_24100006_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } arb_state_e;

  typedef logic arb_gnt_t;

  localparam arb_gnt_t GNT_IFU = 1'b0;
  localparam arb_gnt_t GNT_LSU = 1'b1;

  localparam int unsigned ARB_STRB_W = 8;

  // Under contention the master that did not win last time gets the bus.
  function automatic arb_gnt_t pick_winner(input logic ifu_req, input logic lsu_req,
                                           input arb_gnt_t last_grant);
    arb_gnt_t winner;
    if (ifu_req && lsu_req) begin
      winner = (last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
    end else if (ifu_req) begin
      winner = GNT_IFU;
    end else begin
      winner = GNT_LSU;
    end
    return winner;
  endfunction

endpackage

// File: rtl/ysyx_24100006_axi_arbiter_if.sv
// AXI-lite bundle shared by the IFU, LSU and crossbar sides of the arbiter.
// The master modport is the side that issues requests.
interface ysyx_24100006_axi_arbiter_if
  import ysyx_24100006_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = ARB_STRB_W
);

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/ysyx_24100006_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-master AXI-lite arbiter.
// One transaction per grant, round-robin under contention, no buffering.
module ysyx_24100006_axi_arbiter
  import ysyx_24100006_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  ysyx_24100006_axi_arbiter_if.slave   ifu_axi,
  ysyx_24100006_axi_arbiter_if.slave   lsu_axi,
  ysyx_24100006_axi_arbiter_if.master  m_axi
);

  arb_state_e state_q, state_d;
  arb_gnt_t   last_grant_q, last_grant_d;

  logic ifu_req_s;
  logic lsu_rd_s;
  logic lsu_wr_s;
  logic lsu_req_s;

  assign ifu_req_s = ifu_axi.arvalid;
  assign lsu_rd_s  = lsu_axi.arvalid;
  assign lsu_wr_s  = lsu_axi.awvalid | lsu_axi.wvalid;
  assign lsu_req_s = lsu_rd_s | lsu_wr_s;

  // Next-state: arbitrate in IDLE, release the grant on the response handshake.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (ifu_req_s || lsu_req_s) begin
          if (pick_winner(ifu_req_s, lsu_req_s, last_grant_q) == GNT_IFU) begin
            state_d      = IFU_RD;
            last_grant_d = GNT_IFU;
          end else begin
            // A simultaneous LSU read and write serves the read first.
            state_d      = lsu_rd_s ? LSU_RD : LSU_WR;
            last_grant_d = GNT_LSU;
          end
        end else begin
          state_d = IDLE;
        end
      end
      IFU_RD: begin
        if (m_axi.rvalid && ifu_axi.rready) begin
          state_d = IDLE;
        end else begin
          state_d = IFU_RD;
        end
      end
      LSU_RD: begin
        if (m_axi.rvalid && lsu_axi.rready) begin
          state_d = IDLE;
        end else begin
          state_d = LSU_RD;
        end
      end
      LSU_WR: begin
        if (m_axi.bvalid && lsu_axi.bready) begin
          state_d = IDLE;
        end else begin
          state_d = LSU_WR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and round-robin history; reset leaves LSU as last so IFU wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_LSU;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Routing: everything is zero unless the current state owns the channel.
  always_comb begin
    m_axi.awvalid   = 1'b0;
    m_axi.awaddr    = {ADDR_W{1'b0}};
    m_axi.wvalid    = 1'b0;
    m_axi.wdata     = {DATA_W{1'b0}};
    m_axi.wstrb     = {ARB_STRB_W{1'b0}};
    m_axi.bready    = 1'b0;
    m_axi.arvalid   = 1'b0;
    m_axi.araddr    = {ADDR_W{1'b0}};
    m_axi.rready    = 1'b0;

    ifu_axi.awready = 1'b0;
    ifu_axi.wready  = 1'b0;
    ifu_axi.bvalid  = 1'b0;
    ifu_axi.bresp   = 2'b00;
    ifu_axi.arready = 1'b0;
    ifu_axi.rvalid  = 1'b0;
    ifu_axi.rdata   = {DATA_W{1'b0}};
    ifu_axi.rresp   = 2'b00;

    lsu_axi.awready = 1'b0;
    lsu_axi.wready  = 1'b0;
    lsu_axi.bvalid  = 1'b0;
    lsu_axi.bresp   = 2'b00;
    lsu_axi.arready = 1'b0;
    lsu_axi.rvalid  = 1'b0;
    lsu_axi.rdata   = {DATA_W{1'b0}};
    lsu_axi.rresp   = 2'b00;

    case (state_q)
      IFU_RD: begin
        m_axi.arvalid   = ifu_axi.arvalid;
        m_axi.araddr    = ifu_axi.araddr;
        m_axi.rready    = ifu_axi.rready;
        ifu_axi.arready = m_axi.arready;
        ifu_axi.rvalid  = m_axi.rvalid;
        ifu_axi.rdata   = m_axi.rdata;
        ifu_axi.rresp   = m_axi.rresp;
      end
      LSU_RD: begin
        m_axi.arvalid   = lsu_axi.arvalid;
        m_axi.araddr    = lsu_axi.araddr;
        m_axi.rready    = lsu_axi.rready;
        lsu_axi.arready = m_axi.arready;
        lsu_axi.rvalid  = m_axi.rvalid;
        lsu_axi.rdata   = m_axi.rdata;
        lsu_axi.rresp   = m_axi.rresp;
      end
      LSU_WR: begin
        // AW and W pass through independently; the slave may take either first.
        m_axi.awvalid   = lsu_axi.awvalid;
        m_axi.awaddr    = lsu_axi.awaddr;
        m_axi.wvalid    = lsu_axi.wvalid;
        m_axi.wdata     = lsu_axi.wdata;
        m_axi.wstrb     = lsu_axi.wstrb;
        m_axi.bready    = lsu_axi.bready;
        lsu_axi.awready = m_axi.awready;
        lsu_axi.wready  = m_axi.wready;
        lsu_axi.bvalid  = m_axi.bvalid;
        lsu_axi.bresp   = m_axi.bresp;
      end
      default: begin
        m_axi.arvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Self-checking bench for the IFU/LSU AXI-lite arbiter: directed scenarios
// followed by random traffic, all compared against a transaction-level model.
module tb_ysyx_24100006_axi_arbiter;

  logic clk;
  logic reset;

  ysyx_24100006_axi_arbiter_if ifu_if ();
  ysyx_24100006_axi_arbiter_if lsu_if ();
  ysyx_24100006_axi_arbiter_if m_if ();

  ysyx_24100006_axi_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .ifu_axi (ifu_if.slave),
    .lsu_axi (lsu_if.slave),
    .m_axi   (m_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: who owns the bus (0 none, 1 IFU read, 2 LSU read, 3 LSU write)
  // and who was granted last (0 IFU, 1 LSU).
  int owner  = 0;
  int last_g = 1;
  int nxt_owner;
  int nxt_last;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    ifu_if.arvalid = 1'b0; ifu_if.araddr = 32'h0; ifu_if.rready = 1'b0;
    ifu_if.awvalid = 1'b0; ifu_if.awaddr = 32'h0; ifu_if.wvalid = 1'b0;
    ifu_if.wdata = 32'h0; ifu_if.wstrb = 8'h0; ifu_if.bready = 1'b0;
    lsu_if.arvalid = 1'b0; lsu_if.araddr = 32'h0; lsu_if.rready = 1'b0;
    lsu_if.awvalid = 1'b0; lsu_if.awaddr = 32'h0; lsu_if.wvalid = 1'b0;
    lsu_if.wdata = 32'h0; lsu_if.wstrb = 8'h0; lsu_if.bready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0; m_if.bresp = 2'b00;
    m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = 32'h0; m_if.rresp = 2'b00;
  endtask

  // Expected routing: the owner's channels are wired through, everything else is 0.
  task automatic check_all();
    logic [33:0] rd_src;
    logic [74:0] wr_src;
    logic [35:0] rd_rsp;
    logic [4:0]  wr_rsp;
    rd_src = 34'h0;
    if (owner == 1) rd_src = {ifu_if.arvalid, ifu_if.araddr, ifu_if.rready};
    if (owner == 2) rd_src = {lsu_if.arvalid, lsu_if.araddr, lsu_if.rready};
    wr_src = (owner == 3) ? {lsu_if.awvalid, lsu_if.awaddr, lsu_if.wvalid, lsu_if.wdata,
                             lsu_if.wstrb, lsu_if.bready} : 75'h0;
    rd_rsp = {m_if.arready, m_if.rvalid, m_if.rdata, m_if.rresp};
    wr_rsp = {m_if.awready, m_if.wready, m_if.bvalid, m_if.bresp};
    chk("m_side", {m_if.arvalid, m_if.araddr, m_if.rready, m_if.awvalid, m_if.awaddr,
                   m_if.wvalid, m_if.wdata, m_if.wstrb, m_if.bready}, {rd_src, wr_src});
    chk("ifu_side", {ifu_if.arready, ifu_if.rvalid, ifu_if.rdata, ifu_if.rresp,
                     ifu_if.awready, ifu_if.wready, ifu_if.bvalid, ifu_if.bresp},
        {((owner == 1) ? rd_rsp : 36'h0), 5'h0});
    chk("lsu_side", {lsu_if.arready, lsu_if.rvalid, lsu_if.rdata, lsu_if.rresp,
                     lsu_if.awready, lsu_if.wready, lsu_if.bvalid, lsu_if.bresp},
        {((owner == 2) ? rd_rsp : 36'h0), ((owner == 3) ? wr_rsp : 5'h0)});
  endtask

  // One clock: settle, check, predict the next owner, advance past the edge.
  task automatic cycle();
    bit ifu_r, lsu_any, ifu_wins;
    #1;
    if (reset) begin owner = 0; last_g = 1; end
    check_all();
    nxt_owner = owner;
    nxt_last  = last_g;
    ifu_r   = ifu_if.arvalid;
    lsu_any = lsu_if.arvalid | lsu_if.awvalid | lsu_if.wvalid;
    if (reset) begin
      nxt_owner = 0; nxt_last = 1;
    end else if (owner == 0 && (ifu_r || lsu_any)) begin
      ifu_wins = ifu_r && (!lsu_any || last_g == 1);
      nxt_last = ifu_wins ? 0 : 1;
      nxt_owner = ifu_wins ? 1 : (lsu_if.arvalid ? 2 : 3);
    end else if ((owner == 1 && m_if.rvalid && ifu_if.rready) ||
                 (owner == 2 && m_if.rvalid && lsu_if.rready) ||
                 (owner == 3 && m_if.bvalid && lsu_if.bready)) begin
      nxt_owner = 0;
    end
    @(posedge clk);
    #1;
    owner  = nxt_owner;
    last_g = nxt_last;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    cycle();
    reset = 1'b0;
  endtask

  logic [31:0] grant_addr [3];

  initial begin
    reset = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    chk("reset_m_arvalid", {m_if.arvalid, m_if.awvalid, m_if.wvalid}, 3'b000);
    cycle();
    reset = 1'b0;
    cycle();

    // IFU fetch: 1-cycle arbitration latency, data forwarded, back to IDLE.
    ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h8000_0000; ifu_if.rready = 1'b1;
    m_if.arready = 1'b1;
    #1; chk("t1_lat0", m_if.arvalid, 1'b0);
    cycle();
    chk("t1_arvalid", {m_if.arvalid, m_if.araddr}, {1'b1, 32'h8000_0000});
    cycle();
    ifu_if.arvalid = 1'b0; m_if.rvalid = 1'b1; m_if.rdata = 32'h0000_0413;
    #1; chk("t1_rdata", ifu_if.rdata, 32'h0000_0413);
    chk("t1_lsu_arready", lsu_if.arready, 1'b0);
    cycle();
    chk("t1_idle", {m_if.rready, ifu_if.rvalid}, 2'b00);
    drive_idle();
    cycle();

    // Contention three times: IFU, LSU, IFU.
    do_reset();
    grant_addr[0] = 32'h0000_1000; grant_addr[1] = 32'h0000_2000; grant_addr[2] = 32'h0000_1000;
    ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h0000_1000; ifu_if.rready = 1'b1;
    lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h0000_2000; lsu_if.rready = 1'b1;
    m_if.arready = 1'b1; m_if.rvalid = 1'b1; m_if.rdata = 32'h1234_5678;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k % 2 == 1) begin
        chk("t2_grant_addr", m_if.araddr, grant_addr[k/2]);
        chk("t2_loser_arready", (k == 3) ? ifu_if.arready : lsu_if.arready, 1'b0);
      end
      cycle();
    end
    drive_idle();
    cycle();

    // LSU write with W accepted two cycles before AW; IFU blocked meanwhile.
    ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h0000_3000; ifu_if.rready = 1'b1;
    lsu_if.awvalid = 1'b1; lsu_if.awaddr = 32'ha000_03f8;
    lsu_if.wvalid = 1'b1; lsu_if.wdata = 32'h0000_0041; lsu_if.wstrb = 8'h01;
    lsu_if.bready = 1'b1;
    cycle();
    m_if.wready = 1'b1;
    #1; chk("t3_w_fwd", {m_if.wvalid, m_if.wdata, m_if.wstrb, m_if.awvalid},
            {1'b1, 32'h0000_0041, 8'h01, 1'b1});
    chk("t3_ifu_blocked", {m_if.arvalid, ifu_if.arready}, 2'b00);
    cycle();
    lsu_if.wvalid = 1'b0; m_if.wready = 1'b0;
    cycle();
    m_if.awready = 1'b1;
    #1; chk("t3_aw_fwd", {lsu_if.awready, m_if.awaddr}, {1'b1, 32'ha000_03f8});
    cycle();
    lsu_if.awvalid = 1'b0; m_if.awready = 1'b0; m_if.bvalid = 1'b1;
    #1; chk("t3_bvalid", lsu_if.bvalid, 1'b1);
    cycle();
    m_if.bvalid = 1'b0;
    cycle();
    chk("t3_ifu_after", {m_if.arvalid, m_if.araddr}, {1'b1, 32'h0000_3000});
    m_if.rvalid = 1'b1;
    cycle();
    drive_idle();
    cycle();

    // LSU read and write together: read first, one IDLE cycle, then write.
    lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h0000_4000; lsu_if.rready = 1'b1;
    lsu_if.awvalid = 1'b1; lsu_if.awaddr = 32'h0000_5000; lsu_if.wvalid = 1'b1;
    lsu_if.wdata = 32'hdead_beef; lsu_if.wstrb = 8'h0f; lsu_if.bready = 1'b1;
    cycle();
    chk("t4_rd_first", {m_if.arvalid, m_if.awvalid}, 2'b10);
    m_if.arready = 1'b1; m_if.rvalid = 1'b1;
    cycle();
    lsu_if.arvalid = 1'b0; m_if.arready = 1'b0; m_if.rvalid = 1'b0;
    #1; chk("t4_gap", {m_if.arvalid, m_if.awvalid}, 2'b00);
    cycle();
    chk("t4_wr_next", {m_if.awvalid, m_if.awaddr}, {1'b1, 32'h0000_5000});
    m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.bvalid = 1'b1;
    cycle();
    drive_idle();
    cycle();

    // Reset while an LSU read response is pending, then IFU wins the next tie.
    lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h0000_6000;
    ifu_if.arvalid = 1'b0;
    cycle();
    m_if.rvalid = 1'b1; m_if.rdata = 32'h0bad_cafe;
    #1; chk("t5_pending", lsu_if.rvalid, 1'b1);
    #2; reset = 1'b1;
    #1; chk("t5_async_zero", {lsu_if.rvalid, m_if.arvalid, m_if.rready}, 3'b000);
    cycle();
    reset = 1'b0;
    drive_idle();
    ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h0000_7000;
    lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h0000_8000;
    cycle();
    chk("t5_ifu_wins", m_if.araddr, 32'h0000_7000);
    ifu_if.rready = 1'b1; m_if.rvalid = 1'b1; m_if.rresp = 2'b10;
    lsu_if.arvalid = 1'b0;
    #1; chk("t6_rresp", ifu_if.rresp, 2'b10);
    cycle();
    chk("t6_idle", {m_if.arvalid, ifu_if.rvalid}, 2'b00);
    drive_idle();
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      ifu_if.arvalid = ($urandom_range(0, 2) == 0); ifu_if.araddr = $urandom;
      ifu_if.rready  = 1'($urandom);
      lsu_if.arvalid = ($urandom_range(0, 2) == 0); lsu_if.araddr = $urandom;
      lsu_if.rready  = 1'($urandom);
      lsu_if.awvalid = ($urandom_range(0, 3) == 0); lsu_if.awaddr = $urandom;
      lsu_if.wvalid  = ($urandom_range(0, 3) == 0); lsu_if.wdata = $urandom;
      lsu_if.wstrb   = 8'($urandom); lsu_if.bready = 1'($urandom);
      m_if.arready = 1'($urandom); m_if.rvalid = 1'($urandom); m_if.rdata = $urandom;
      m_if.rresp   = 2'($urandom);
      m_if.awready = 1'($urandom); m_if.wready = 1'($urandom); m_if.bvalid = 1'($urandom);
      m_if.bresp   = 2'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
